// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial add/subtract sequencer:
//   - FSM state encoding (2'd3 is unused and recovers to IDLE)
//   - operation select constants for the 'sub' input
// ----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// ----------------------------------------------------------------------------
// fulladder
// Single-bit full-adder cell.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   cout  : carry out
//   sum   : sum bit
// ----------------------------------------------------------------------------
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial add/subtract sequencer. Operands are accepted through a
// start/ready handshake and fed LSB first, one bit pair per clock, into a
// single full-adder cell. Sum bits are shifted into 'result' from the MSB
// end, so after WIDTH run cycles the word is aligned. Subtraction is done
// as a + ~b + 1 (the +1 is the preset carry).
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : request, accepted only while ready=1
//   sub       : 0 = a+b, 1 = a-b (sampled with start)
//   a, b      : WIDTH-bit operands (sampled with start)
//   ready     : block can accept start this cycle
//   done      : one-cycle pulse, result/cout/overflow valid
//   result    : sum/difference, held until the next accepted start
//   cout      : final carry out (for sub: 1 = no borrow)
//   overflow  : signed overflow (carry into MSB xor carry out of MSB)
//
// State table:
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for start, ready=1
//   ST_RUN  | one bit per cycle through the cell, ready=0
//   ST_DONE | done pulse, ready=1; a start here is accepted back-to-back
// ----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    state_e             state_q;
    state_e             state_d;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               last_bit;
    logic               fa_sum;
    logic               fa_cout;

    fulladder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry_q),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    assign accept   = start & ready;
    assign last_bit = (state_q == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                done    = 1'b1;
                state_d = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifters, carry, bit counter, result and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            op_a     <= a;
            op_b     <= (sub == ADD_OP) ? b : ~b;
            carry_q  <= (sub == SUB_OP);
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (state_q == ST_RUN) begin
            // Shift form that stays legal for WIDTH=1 (no [0:1] slice).
            result  <= (result >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
            op_a    <= op_a >> 1;
            op_b    <= op_b >> 1;
            carry_q <= fa_cout;
            cnt     <= cnt + CNT_W'(1);
            if (last_bit) begin
                cout     <= fa_cout;
                overflow <= carry_q ^ fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl at WIDTH = 1, 8 and 32.
// Expected values come from plain integer arithmetic on the operands.
// ----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start [3];
    logic        sub_i [3];
    logic [63:0] a_i   [3];
    logic [63:0] b_i   [3];
    logic        rdy   [3];
    logic        dn    [3];
    logic        co    [3];
    logic        ov    [3];

    logic [0:0]  r_w1;
    logic [7:0]  r_w8;
    logic [31:0] r_w32;

    int widths [3] = '{1, 8, 32};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub_i[0]),
        .a(a_i[0][0:0]), .b(b_i[0][0:0]), .ready(rdy[0]), .done(dn[0]),
        .result(r_w1), .cout(co[0]), .overflow(ov[0])
    );

    serial_adder_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub_i[1]),
        .a(a_i[1][7:0]), .b(b_i[1][7:0]), .ready(rdy[1]), .done(dn[1]),
        .result(r_w8), .cout(co[1]), .overflow(ov[1])
    );

    serial_adder_ctrl #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub_i[2]),
        .a(a_i[2][31:0]), .b(b_i[2][31:0]), .ready(rdy[2]), .done(dn[2]),
        .result(r_w32), .cout(co[2]), .overflow(ov[2])
    );

    function automatic logic [63:0] res_of(int k);
        case (k)
            0:       return 64'(r_w1);
            1:       return 64'(r_w8);
            default: return 64'(r_w32);
        endcase
    endfunction

    function automatic logic [63:0] mask_of(int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: {overflow, cout, result} from integer add/subtract.
    function automatic logic [65:0] model(int w, logic [63:0] av, logic [63:0] bv, logic s);
        logic [63:0] m;
        logic [64:0] tot;
        logic [63:0] r;
        logic        c;
        logic        o;
        logic        sa;
        logic        sb;
        logic        sr;
        m   = mask_of(w);
        av  = av & m;
        bv  = bv & m;
        if (!s) begin
            tot = {1'b0, av} + {1'b0, bv};
            c   = tot[w];
        end else begin
            tot = {1'b0, av} - {1'b0, bv};
            c   = (av >= bv);
        end
        r  = tot[63:0] & m;
        sa = av[w-1];
        sb = bv[w-1];
        sr = r[w-1];
        o  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return {o, c, r};
    endfunction

    function automatic logic [63:0] pick(int w);
        logic [63:0] m;
        m = mask_of(w);
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return m;
            2:       return 64'd1 << (w - 1);
            3:       return (64'd1 << (w - 1)) - 64'd1;
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the instance able to accept; returns at the
    // negedge of the done cycle with start low.
    task automatic run_op(int k, int w, logic [63:0] av, logic [63:0] bv, logic s);
        logic [65:0] m;
        int          lat;
        bit          seen;
        chk("ready_pre", 64'(rdy[k]), 64'd1);
        start[k] = 1'b1;
        a_i[k]   = av;
        b_i[k]   = bv;
        sub_i[k] = s;
        @(negedge clk);
        start[k] = 1'b0;
        a_i[k]   = {$urandom, $urandom};
        b_i[k]   = {$urandom, $urandom};
        sub_i[k] = ~s;
        chk("run1", {62'd0, rdy[k], dn[k]}, 64'd0);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 2 * w + 8) begin
            @(negedge clk);
            lat++;
            if (dn[k]) seen = 1'b1;
            else chk("ready_run", 64'(rdy[k]), 64'd0);
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(lat), 64'(w + 1));
        m = model(w, av, bv, s);
        chk("result", res_of(k), m[63:0]);
        chk("cout", 64'(co[k]), 64'(m[64]));
        chk("overflow", 64'(ov[k]), 64'(m[65]));
        chk("ready_done", 64'(rdy[k]), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  any_done;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            sub_i[k] = 1'b0;
            a_i[k]   = '0;
            b_i[k]   = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", 64'(rdy[k]), 64'd1);
            chk("rst_done", 64'(dn[k]), 64'd0);
            chk("rst_result", res_of(k), 64'd0);
            chk("rst_cout", 64'(co[k]), 64'd0);
            chk("rst_ovf", 64'(ov[k]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, WIDTH=8
        run_op(1, 8, 64'h05, 64'h03, 1'b0);
        @(negedge clk);
        chk("pulse_width", 64'(dn[1]), 64'd0);
        run_op(1, 8, 64'hFF, 64'h01, 1'b0);
        run_op(1, 8, 64'h7F, 64'h01, 1'b0);
        run_op(1, 8, 64'h80, 64'h01, 1'b1);
        run_op(1, 8, 64'h01, 64'h02, 1'b1);
        @(negedge clk);
        chk("pulse_width2", 64'(dn[1]), 64'd0);

        // start held high, operands changed mid-run
        start[1] = 1'b1;
        a_i[1]   = 64'h10;
        b_i[1]   = 64'h20;
        sub_i[1] = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 4) begin
                a_i[1] = 64'hAA;
                b_i[1] = 64'h55;
            end
            if (dn[1]) break;
        end
        chk("hold_lat1", 64'(lat), 64'd9);
        chk("hold_res1", res_of(1), 64'h30);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (dn[1]) break;
        end
        start[1] = 1'b0;
        chk("hold_lat2", 64'(lat), 64'd9);
        chk("hold_res2", res_of(1), 64'hFF);
        chk("hold_cout2", 64'(co[1]), 64'd0);
        chk("hold_ovf2", 64'(ov[1]), 64'd0);
        @(negedge clk);
        chk("hold_idle_ready", 64'(rdy[1]), 64'd1);
        chk("hold_idle_done", 64'(dn[1]), 64'd0);

        // Asynchronous reset in RUN cycle 4
        start[1] = 1'b1;
        a_i[1]   = 64'h5A;
        b_i[1]   = 64'h33;
        sub_i[1] = 1'b0;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(rdy[1]), 64'd1);
        chk("arst_done", 64'(dn[1]), 64'd0);
        chk("arst_result", res_of(1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        any_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (dn[1]) any_done = 1'b1;
        end
        chk("arst_no_done", 64'(any_done), 64'd0);
        run_op(1, 8, 64'h21, 64'h13, 1'b0);
        @(negedge clk);

        // Random sweep for each width, with random back-to-back issue
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 1000; n++) begin
                run_op(k, widths[k], pick(widths[k]), pick(widths[k]), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) != 0) begin
                    @(negedge clk);
                    chk("pulse_w", 64'(dn[k]), 64'd0);
                end
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
